// File: rtl/level_sequencer.sv
// level_sequencer: frame-rate game controller for the platformer datapath.
//
// Walks the game through idle, level load, play, pause, level-clear hold, death hold,
// game-over and win. It pulses new_level to reinitialise the player block, selects the
// level index for the map/spawn ROM, gates the player controls and tracks player lives.
//
// Parameters (all expected to be >= 1):
//   NUM_LEVELS       number of levels (1..8)
//   MAX_PLAYER_LIVES player lives at game start (1..15)
//   CLEAR_FRAMES     frames held in CLEAR before the next level
//   DEATH_FRAMES     frames held in DEATH before respawn
//
// Ports:
//   frame_clk    in   frame clock, every action happens on its rising edge
//   Reset        in   asynchronous active-low reset
//   start        in   start/continue key, acted on at its rising edge
//   pause        in   pause key, acted on at its rising edge
//   player_dead  in   hazard/fall flag from collision logic
//   enemy_lives  in   enemy lives from the player block, zero means level cleared
//   new_level    out  one-cycle reinitialise pulse (high in LOAD)
//   play_en      out  high only in PLAY, gates movement and shooting
//   level        out  current level index
//   player_lives out  remaining player lives
//   state        out  state code for the HUD/message sprite
//   timer        out  remaining hold frames in CLEAR/DEATH, 0 otherwise

module level_sequencer #(
    parameter int unsigned NUM_LEVELS       = 4,
    parameter int unsigned MAX_PLAYER_LIVES = 3,
    parameter int unsigned CLEAR_FRAMES     = 120,
    parameter int unsigned DEATH_FRAMES     = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       pause,
    input  logic       player_dead,
    input  logic [9:0] enemy_lives,
    output logic       new_level,
    output logic       play_en,
    output logic [2:0] level,
    output logic [3:0] player_lives,
    output logic [3:0] state,
    output logic [7:0] timer
);

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoad  = 4'd1,
        StArm   = 4'd2,
        StPlay  = 4'd3,
        StPause = 4'd4,
        StClear = 4'd5,
        StDeath = 4'd6,
        StOver  = 4'd7,
        StWin   = 4'd8
    } state_e;

    localparam logic [2:0] LastLevel = 3'(NUM_LEVELS - 1);
    localparam logic [3:0] LivesInit = 4'(MAX_PLAYER_LIVES);
    localparam logic [7:0] ClearInit = 8'(CLEAR_FRAMES - 1);
    localparam logic [7:0] DeathInit = 8'(DEATH_FRAMES - 1);

    state_e     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic [3:0] lives_q, lives_d;
    logic [7:0] timer_q, timer_d;
    logic       start_q, pause_q;
    logic       start_rise, pause_rise;

    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            level_q <= '0;
            lives_q <= LivesInit;
            timer_q <= '0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            start_q <= start;
            pause_q <= pause;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        // Timer is only kept alive by CLEAR/DEATH, so every other state zeroes it.
        timer_d = '0;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    level_d = '0;
                    lives_d = LivesInit;
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StArm;
            // Settling frame: enemy_lives is still stale from the previous level here.
            StArm:  state_d = StPlay;
            StPlay: begin
                // A clear wins over a simultaneous death, and no life is taken.
                if (enemy_lives == '0) begin
                    state_d = StClear;
                    timer_d = ClearInit;
                end else if (player_dead) begin
                    if (lives_q <= 4'd1) begin
                        lives_d = '0;
                        state_d = StOver;
                    end else begin
                        lives_d = lives_q - 4'd1;
                        state_d = StDeath;
                        timer_d = DeathInit;
                    end
                end else if (pause_rise) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (pause_rise) state_d = StPlay;
            end
            StClear: begin
                if (timer_q == '0) begin
                    if (level_q >= LastLevel) begin
                        state_d = StWin;
                    end else begin
                        level_d = level_q + 3'd1;
                        state_d = StLoad;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            StDeath: begin
                if (timer_q == '0) begin
                    state_d = StLoad;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            StOver, StWin: begin
                if (start_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign state        = state_q;
    assign new_level    = (state_q == StLoad);
    assign play_en      = (state_q == StPlay);
    assign level        = level_q;
    assign player_lives = lives_q;
    assign timer        = timer_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with default parameters.
module tb_level_sequencer;

    logic       frame_clk;
    logic       Reset;
    logic       start;
    logic       pause;
    logic       player_dead;
    logic [9:0] enemy_lives;
    logic       new_level;
    logic       play_en;
    logic [2:0] level;
    logic [3:0] player_lives;
    logic [3:0] state;
    logic [7:0] timer;

    int checks = 0;
    int errors = 0;

    level_sequencer #(
        .NUM_LEVELS      (4),
        .MAX_PLAYER_LIVES(3),
        .CLEAR_FRAMES    (120),
        .DEATH_FRAMES    (60)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .start       (start),
        .pause       (pause),
        .player_dead (player_dead),
        .enemy_lives (enemy_lives),
        .new_level   (new_level),
        .play_en     (play_en),
        .level       (level),
        .player_lives(player_lives),
        .state       (state),
        .timer       (timer)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " state"}, 32'(state), 0);
        chk({tag, " new_level"}, 32'(new_level), 0);
        chk({tag, " play_en"}, 32'(play_en), 0);
        chk({tag, " level"}, 32'(level), 0);
        chk({tag, " lives"}, 32'(player_lives), 3);
        chk({tag, " timer"}, 32'(timer), 0);
    endtask

    // From PLAY: clear the level, run out the 120-frame hold, land back in PLAY.
    task automatic clear_to_next(input int next_level);
        enemy_lives = 10'd0;
        step(1);
        chk("clr state", 32'(state), 5);
        chk("clr timer", 32'(timer), 119);
        enemy_lives = 10'd10;
        step(120);
        chk("clr load", 32'(new_level), 1);
        chk("clr level", 32'(level), 32'(next_level));
        step(2);
        chk("clr play", 32'(state), 3);
    endtask

    initial begin
        Reset       = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        player_dead = 1'b0;
        enemy_lives = 10'd10;
        #12;
        chk_reset_values("rst");
        Reset = 1'b1;
        step(1);
        chk("idle", 32'(state), 0);

        // Start held three frames: single LOAD pulse, then ARM, then PLAY.
        start = 1'b1;
        step(1);
        chk("start load", 32'(state), 1);
        chk("start pulse", 32'(new_level), 1);
        step(1);
        chk("start arm", 32'(state), 2);
        chk("arm no pulse", 32'(new_level), 0);
        chk("arm play_en", 32'(play_en), 0);
        step(1);
        chk("start play_en", 32'(play_en), 1);
        chk("start level", 32'(level), 0);
        chk("start lives", 32'(player_lives), 3);
        start = 1'b0;
        step(3);
        chk("no second load", 32'(state), 3);

        // Level 0 clear.
        enemy_lives = 10'd0;
        step(1);
        chk("clear state", 32'(state), 5);
        chk("clear timer", 32'(timer), 119);
        chk("clear play_en", 32'(play_en), 0);
        enemy_lives = 10'd10;
        step(119);
        chk("clear timer end", 32'(timer), 0);
        chk("clear still", 32'(state), 5);
        step(1);
        chk("clear load", 32'(new_level), 1);
        chk("clear level1", 32'(level), 1);
        chk("clear timer zero", 32'(timer), 0);
        step(2);
        chk("clear replay", 32'(state), 3);

        // Two deaths with respawn, then game over.
        for (int d = 0; d < 2; d++) begin
            player_dead = 1'b1;
            step(1);
            player_dead = 1'b0;
            chk("death state", 32'(state), 6);
            chk("death lives", 32'(player_lives), 32'(2 - d));
            chk("death timer", 32'(timer), 59);
            step(59);
            chk("death hold", 32'(state), 6);
            chk("death timer end", 32'(timer), 0);
            step(1);
            chk("death load", 32'(new_level), 1);
            chk("death level", 32'(level), 1);
            step(2);
            chk("death replay", 32'(state), 3);
        end
        player_dead = 1'b1;
        step(1);
        player_dead = 1'b0;
        chk("over state", 32'(state), 7);
        chk("over lives", 32'(player_lives), 0);
        chk("over timer", 32'(timer), 0);
        step(2);
        chk("over hold", 32'(state), 7);
        chk("over level", 32'(level), 1);

        // OVER -> IDLE on a rise; holding start must not restart.
        start = 1'b1;
        step(1);
        chk("over idle", 32'(state), 0);
        step(2);
        chk("held start idle", 32'(state), 0);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        chk("restart load", 32'(state), 1);
        chk("restart level", 32'(level), 0);
        chk("restart lives", 32'(player_lives), 3);
        start = 1'b0;
        step(2);
        chk("restart play", 32'(state), 3);

        // Clear and death in the same frame counts as a clear.
        enemy_lives = 10'd0;
        player_dead = 1'b1;
        step(1);
        chk("both state", 32'(state), 5);
        chk("both lives", 32'(player_lives), 3);
        enemy_lives = 10'd10;
        player_dead = 1'b0;
        step(120);
        chk("both load", 32'(new_level), 1);
        chk("both level", 32'(level), 1);
        step(2);
        clear_to_next(2);
        clear_to_next(3);

        // Last level clear -> WIN.
        enemy_lives = 10'd0;
        step(1);
        chk("last clear", 32'(state), 5);
        enemy_lives = 10'd10;
        step(120);
        chk("win state", 32'(state), 8);
        chk("win level", 32'(level), 3);
        chk("win timer", 32'(timer), 0);
        start = 1'b1;
        step(1);
        chk("win idle", 32'(state), 0);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        chk("win restart", 32'(state), 1);
        chk("win restart lvl", 32'(level), 0);
        chk("win restart lives", 32'(player_lives), 3);
        start = 1'b0;
        step(2);

        // Pause ignores death and clear, second rise resumes.
        pause = 1'b1;
        step(1);
        chk("pause state", 32'(state), 4);
        chk("pause play_en", 32'(play_en), 0);
        pause = 1'b0;
        player_dead = 1'b1;
        enemy_lives = 10'd0;
        step(3);
        chk("pause ignore", 32'(state), 4);
        chk("pause lives", 32'(player_lives), 3);
        player_dead = 1'b0;
        enemy_lives = 10'd10;
        pause = 1'b1;
        step(1);
        chk("resume state", 32'(state), 3);
        chk("resume play_en", 32'(play_en), 1);
        step(2);
        chk("pause held", 32'(state), 3);
        pause = 1'b0;
        step(1);

        // Asynchronous reset mid-frame during CLEAR.
        enemy_lives = 10'd0;
        step(1);
        enemy_lives = 10'd10;
        step(69);
        chk("pre-reset timer", 32'(timer), 50);
        chk("pre-reset state", 32'(state), 5);
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_values("async");
        step(1);
        Reset = 1'b1;
        step(2);
        chk("post-reset idle", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
